// File: rtl/cordic_sign_pkg.sv
// Shared encodings and helpers for the CORDIC output sign-correction stage.
// Optional build macro used by the top level: SIGN_CORR_NEG_ZERO_CLAMP_EN.
package cordic_sign_pkg;

    // Widest IEEE-754 word the helper handles (double precision)
    localparam int MAX_W = 64;

    // Shift region recorded by range reduction
    localparam logic [1:0] REG_NONE    = 2'b00;
    localparam logic [1:0] REG_NEG_COS = 2'b01;
    localparam logic [1:0] REG_NEG_SIN = 2'b10;
    localparam logic [1:0] REG_NONE2   = 2'b11;

    // Which result the operation asked for
    localparam logic OP_COS = 1'b0;
    localparam logic OP_SIN = 1'b1;

    typedef struct packed {
        logic [1:0] region;
        logic       op;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Invert the sign bit at sign_pos when en is set; all other bits pass through
    function automatic logic [MAX_W-1:0] flip_sign(input logic [MAX_W-1:0] word,
                                                   input logic             en,
                                                   input logic [5:0]       sign_pos = 6'd31);
        logic [MAX_W-1:0] r;
        r           = word;
        r[sign_pos] = word[sign_pos] ^ en;
        return r;
    endfunction

endpackage

// File: rtl/region_tag_fifo.sv
// Circular FIFO holding region/op tags of operations in flight.
// Pushes while full are ignored; pops while empty are ignored.
module region_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TW    = 3,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [TW-1:0] din,
    input  logic          pop,
    output logic [TW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [TW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage carries no reset; only valid entries are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cordic_sign_corrector.sv
// Quadrant sign correction at the CORDIC output. Tags queued at launch are
// matched in order with result pairs; the sign bit of cos or sin is inverted
// by region and the corrected pair is presented on a registered valid/ready port.
// Optional: define SIGN_CORR_NEG_ZERO_CLAMP_EN to force any -0 output to +0.
module cordic_sign_corrector
    import cordic_sign_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tag_push_i,
    input  logic [1:0]   tag_region_i,
    input  logic         tag_op_i,
    output logic         tag_full_o,
    input  logic         res_valid_i,
    output logic         res_ready_o,
    input  logic [W-1:0] res_cos_i,
    input  logic [W-1:0] res_sin_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_cos_o,
    output logic [W-1:0] out_sin_o,
    output logic [W-1:0] out_data_o,
    output logic         out_op_o,
    output logic         err_ovf_o,
    output logic         err_unf_o
);

    localparam int AW = $clog2(DEPTH);

    tag_t          tag_in;
    tag_t          head;
    logic [AW:0]   tag_count;
    logic          tag_empty;
    logic          accept;
    logic [W-1:0]  cos_c;
    logic [W-1:0]  sin_c;
    logic [W-1:0]  cos_p1;
    logic [W-1:0]  sin_p1;
    logic          op_p1;
    logic          vld_p1;

`ifdef SIGN_CORR_NEG_ZERO_CLAMP_EN
    // A zero magnitude always leaves the stage as +0
    function automatic logic [W-1:0] clamp_neg_zero(input logic [W-1:0] v);
        if (v[W-2:0] == '0) return '0;
        return v;
    endfunction
`endif

    assign tag_in.region = tag_region_i;
    assign tag_in.op     = tag_op_i;

    region_tag_fifo #(
        .DEPTH (DEPTH),
        .TW    (TAG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push_i),
        .din   (tag_in),
        .pop   (accept),
        .dout  (head),
        .count (tag_count),
        .full  (tag_full_o),
        .empty (tag_empty)
    );

    // Start-of-cycle count only, so a tag pushed this cycle cannot be consumed
    assign res_ready_o = !tag_empty && (!vld_p1 || out_ready_i);
    assign accept      = res_valid_i && res_ready_o;

    // Stage p0: combinational correction of the incoming pair using the head tag
    always_comb begin
        cos_c = W'(flip_sign(MAX_W'(res_cos_i), head.region == REG_NEG_COS, 6'(W-1)));
        sin_c = W'(flip_sign(MAX_W'(res_sin_i), head.region == REG_NEG_SIN, 6'(W-1)));
`ifdef SIGN_CORR_NEG_ZERO_CLAMP_EN
        cos_c = clamp_neg_zero(cos_c);
        sin_c = clamp_neg_zero(sin_c);
`endif
    end

    // Stage p1: output register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            cos_p1 <= '0;
            sin_p1 <= '0;
            op_p1  <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            cos_p1 <= cos_c;
            sin_p1 <= sin_c;
            op_p1  <= head.op;
        end else if (out_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    // Sticky error flags; overflow counts even when a pop frees a slot this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_o <= 1'b0;
            err_unf_o <= 1'b0;
        end else begin
            if (tag_push_i && (tag_count == (AW+1)'(DEPTH))) err_ovf_o <= 1'b1;
            if (res_valid_i && tag_empty)                    err_unf_o <= 1'b1;
        end
    end

    assign out_valid_o = vld_p1;
    assign out_cos_o   = cos_p1;
    assign out_sin_o   = sin_p1;
    assign out_op_o    = op_p1;
    assign out_data_o  = (op_p1 == OP_SIN) ? sin_p1 : cos_p1;

endmodule
